// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: stall/flush masks for NSTAGE registers, sequenced
// multi-cycle stalls, bus-freeze-tolerant jump redirect. Optional perf counters: HOLD_PERF_CNT_EN.
module pipe_hold_ctrl #(
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned EX_IDX = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_bus_wait,
  input  logic              i_mc_start,
  input  logic [CNT_W-1:0]  i_mc_cycles,
  input  logic              i_jump_req,
  input  logic [ADDR_W-1:0] i_jump_addr,
  input  logic              i_load_use,
  output logic [NSTAGE-1:0] o_stall,
  output logic [NSTAGE-1:0] o_flush,
  output logic              o_jump_flag,
  output logic [ADDR_W-1:0] o_jump_addr,
  output logic              o_mc_done,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
);

  typedef enum logic {ST_RUN, ST_MC} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, mc_eff;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [NSTAGE-1:0]   mc_stall, mc_flush, jmp_flush, lu_stall, lu_flush;

  always_comb begin
    mc_stall  = '0;
    mc_flush  = '0;
    jmp_flush = '0;
    lu_stall  = '0;
    lu_flush  = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      mc_stall[k]  = (k <= EX_IDX);
      mc_flush[k]  = (k == EX_IDX + 1);
      jmp_flush[k] = (k >= 1) && (k <= EX_IDX);
      lu_stall[k]  = (k <= 1);
      lu_flush[k]  = (k == 2);
    end
  end

  // The issue cycle is the first stall cycle: mc_eff is the count for that cycle,
  // so the MC state is entered with mc_eff-1 remaining (or mc_eff when frozen).
  always_comb begin
    mc_eff      = (i_mc_cycles == '0) ? '0 : i_mc_cycles - 1'b1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    o_stall     = '0;
    o_flush     = '0;
    o_jump_flag = 1'b0;
    o_jump_addr = '0;
    o_mc_done   = 1'b0;
    if (!i_reset) begin
      state_d     = ST_RUN;
      cnt_d       = '0;
      pend_d      = 1'b0;
      pend_addr_d = '0;
    end else if (i_bus_wait) begin
      o_stall = '1;
      if (state_q == ST_RUN) begin
        if (i_jump_req && !pend_q) begin
          pend_d      = 1'b1;
          pend_addr_d = i_jump_addr;
        end else if (i_mc_start && !i_jump_req && !pend_q) begin
          state_d = ST_MC;
          cnt_d   = mc_eff;
        end
      end
    end else if (state_q == ST_MC) begin
      o_stall = mc_stall;
      o_flush = mc_flush;
      if (cnt_q == '0) begin
        o_mc_done = 1'b1;
        state_d   = ST_RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (pend_q) begin
      o_jump_flag = 1'b1;
      o_jump_addr = pend_addr_q;
      o_flush     = jmp_flush;
      pend_d      = 1'b0;
      pend_addr_d = '0;
    end else if (i_jump_req) begin
      o_jump_flag = 1'b1;
      o_jump_addr = i_jump_addr;
      o_flush     = jmp_flush;
    end else if (i_mc_start) begin
      o_stall = mc_stall;
      o_flush = mc_flush;
      if (mc_eff == '0) begin
        o_mc_done = 1'b1;
      end else begin
        state_d = ST_MC;
        cnt_d   = mc_eff - 1'b1;
      end
    end else if (i_load_use) begin
      o_stall = lu_stall;
      o_flush = lu_flush;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef HOLD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_stall[0] && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if ((|o_flush) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed self-checking bench for pipe_hold_ctrl (default parameters).
module tb_pipe_hold_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_wait, mc_start, jump_req, load_use;
  logic [5:0]  mc_cycles;
  logic [31:0] jump_addr_in;
  logic [3:0]  stall, flush;
  logic        jump_flag, mc_done;
  logic [31:0] jump_addr_out, stall_cnt, flush_cnt;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.NSTAGE(4), .EX_IDX(2), .ADDR_W(32), .CNT_W(6)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_bus_wait(bus_wait), .i_mc_start(mc_start),
    .i_mc_cycles(mc_cycles), .i_jump_req(jump_req), .i_jump_addr(jump_addr_in),
    .i_load_use(load_use), .o_stall(stall), .o_flush(flush), .o_jump_flag(jump_flag),
    .o_jump_addr(jump_addr_out), .o_mc_done(mc_done), .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, settle, then let the caller check.
  task automatic apply(input logic rs, input logic bw, input logic ms, input logic [5:0] mc,
                       input logic jr, input logic [31:0] ja, input logic lu);
    @(negedge clk);
    rst_n = rs; bus_wait = bw; mc_start = ms; mc_cycles = mc;
    jump_req = jr; jump_addr_in = ja; load_use = lu;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] s, input logic [3:0] f,
                         input logic jf, input logic [31:0] ja, input logic d);
    check({tag, ".stall"}, 64'(stall), 64'(s));
    check({tag, ".flush"}, 64'(flush), 64'(f));
    check({tag, ".jflag"}, 64'(jump_flag), 64'(jf));
    check({tag, ".jaddr"}, 64'(jump_addr_out), 64'(ja));
    check({tag, ".done"}, 64'(mc_done), 64'(d));
  endtask

  initial begin
    rst_n = 1'b0; bus_wait = 0; mc_start = 0; mc_cycles = '0;
    jump_req = 0; jump_addr_in = '0; load_use = 0;

    apply(0, 0, 1, 6'd4, 1, 32'h80, 1);
    chk_out("rst_a", 4'b0000, 4'b0000, 0, 32'h0, 0);
    apply(0, 1, 1, 6'd2, 0, 32'h44, 1);
    chk_out("rst_b", 4'b0000, 4'b0000, 0, 32'h0, 0);
    check("rst.scnt", 64'(stall_cnt), 64'd0);
    check("rst.fcnt", 64'(flush_cnt), 64'd0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("idle0", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 0, 6'd0, 1, 32'h80, 0);
    chk_out("jump", 4'b0000, 4'b0110, 1, 32'h80, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h80, 0);
    chk_out("jump_after", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 0, 6'd0, 0, 32'h0, 1);
    chk_out("lu", 4'b0011, 4'b0100, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("lu_after", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 0, 6'd0, 1, 32'h1234, 1);
    chk_out("jump_lu", 4'b0000, 4'b0110, 1, 32'h1234, 0);

    apply(1, 0, 1, 6'd4, 0, 32'h0, 0);
    chk_out("mc4_c1", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc4_c2", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc4_c3", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc4_c4", 4'b0111, 4'b1000, 0, 32'h0, 1);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc4_end", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 1, 6'd4, 0, 32'h0, 0);
    chk_out("mcbw_c1", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_c2", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 1, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_w1", 4'b1111, 4'b0000, 0, 32'h0, 0);
    apply(1, 1, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_w2", 4'b1111, 4'b0000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_c3", 4'b0111, 4'b1000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_c4", 4'b0111, 4'b1000, 0, 32'h0, 1);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mcbw_end", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 1, 6'd0, 0, 32'h0, 0);
    chk_out("mc0", 4'b0111, 4'b1000, 0, 32'h0, 1);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc0_after", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(1, 0, 1, 6'd5, 1, 32'h40, 0);
    chk_out("mc_jump", 4'b0000, 4'b0110, 1, 32'h40, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("mc_jump_after", 4'b0000, 4'b0000, 0, 32'h0, 0);

    apply(0, 0, 0, 6'd0, 0, 32'h0, 0);
    check("rst2.scnt", 64'(stall_cnt), 64'd0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    apply(1, 1, 0, 6'd0, 1, 32'h200, 0);
    chk_out("bwj_w1", 4'b1111, 4'b0000, 0, 32'h0, 0);
    apply(1, 1, 0, 6'd0, 1, 32'h300, 0);
    chk_out("bwj_w2", 4'b1111, 4'b0000, 0, 32'h0, 0);
    apply(1, 1, 0, 6'd0, 0, 32'h0, 0);
    chk_out("bwj_w3", 4'b1111, 4'b0000, 0, 32'h0, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("bwj_redir", 4'b0000, 4'b0110, 1, 32'h200, 0);
    apply(1, 0, 0, 6'd0, 0, 32'h0, 0);
    chk_out("bwj_after", 4'b0000, 4'b0000, 0, 32'h0, 0);
`ifdef HOLD_PERF_CNT_EN
    check("perf.scnt", 64'(stall_cnt), 64'd3);
    check("perf.fcnt", 64'(flush_cnt), 64'd1);
`else
    check("perf.scnt", 64'(stall_cnt), 64'd0);
    check("perf.fcnt", 64'(flush_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
